// File: rtl/cordic_fp16_pkg.sv
// Shared types and constants for the FP16 -> Q4.12 front end of the CORDIC path.
package cordic_fp16_pkg;
   typedef logic        [15:0] fp16_t;
   typedef logic signed [15:0] fix_q4_12_t;

   localparam int         FP16_BIAS     = 15;
   localparam int         FIX_FRAC_BITS = 12;
   localparam fix_q4_12_t FIX_MAX       = 16'h7FFF;
   localparam fix_q4_12_t FIX_MIN       = 16'h8000;

   // Smallest biased exponent whose magnitude reaches 8.0, the top of Q4.12
   localparam logic [4:0] SAT_EXP = 5'(FP16_BIAS + 3);

   typedef struct packed {
      logic       sign;
      logic [4:0] exp;
      logic [9:0] man;
      logic       is_zero;
      logic       is_nan;
      logic       is_inf;
   } s1_t;
endpackage

// File: rtl/fp16_mag_round.sv
// Combinational shift/round of a normal FP16 magnitude into Q4.12 units.
// FP16_CONV_RNE_EN selects round-to-nearest-even; otherwise truncates toward zero.
module fp16_mag_round
   import cordic_fp16_pkg::*;
(
   input  logic [4:0]  i_exp,
   input  logic [9:0]  i_man,
   output logic [15:0] o_mag,
   output logic        o_big
);
`ifdef FP16_CONV_RNE_EN
   localparam logic RNE = 1'b1;
`else
   localparam logic RNE = 1'b0;
`endif

   logic [26:0] w_val;
   logic        w_rnd;

   // w_val = magnitude * 2^24: integer Q4.12 bits on top, 12 discarded bits below
   assign w_val = 27'({1'b1, i_man}) << (i_exp - 5'd1);
   assign w_rnd = RNE & w_val[FIX_FRAC_BITS-1]
                & ((|w_val[FIX_FRAC_BITS-2:0]) | w_val[FIX_FRAC_BITS]);
   assign o_mag = {1'b0, w_val[26:FIX_FRAC_BITS]} + {15'd0, w_rnd};
   assign o_big = (i_exp >= SAT_EXP);
endmodule

// File: rtl/fp16_to_fixed_conv.sv
// FP16 -> signed Q4.12 converter, 2-stage valid/ready pipeline with saturation counter.
// Rounding mode: FP16_CONV_RNE_EN defined -> RNE, undefined -> truncate.
module fp16_to_fixed_conv
   import cordic_fp16_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  fp16_t       fp16_in,
   output logic        out_valid,
   input  logic        out_ready,
   output fix_q4_12_t  fix_out,
   output logic        out_sat,
   output logic        out_nan,
   output logic [15:0] sat_count
);
   s1_t         r_s1;
   logic        r_s1_vld;
   logic        r_out_vld;
   fix_q4_12_t  r_fix;
   logic        r_sat;
   logic        r_nan;
   logic [15:0] r_sat_cnt;

   s1_t         w_dec;
   logic        w_s2_free, w_s1_adv, w_in_xfer, w_out_xfer;
   logic [15:0] w_mag;
   logic        w_big, w_over, w_exact8;
   fix_q4_12_t  w_fix;
   logic        w_sat, w_nan;

   assign w_out_xfer = r_out_vld & out_ready;
   assign w_s2_free  = ~r_out_vld | out_ready;
   assign w_s1_adv   = r_s1_vld & w_s2_free;
   assign in_ready   = ~r_s1_vld | w_s2_free;
   assign w_in_xfer  = in_valid & in_ready;

   always_comb begin
      w_dec         = '0;
      w_dec.sign    = fp16_in[15];
      w_dec.exp     = fp16_in[14:10];
      w_dec.man     = fp16_in[9:0];
      w_dec.is_zero = (fp16_in[14:10] == 5'd0);
      w_dec.is_nan  = (fp16_in[14:10] == 5'h1F) && (fp16_in[9:0] != 10'd0);
      w_dec.is_inf  = (fp16_in[14:10] == 5'h1F) && (fp16_in[9:0] == 10'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_vld <= 1'b0;
         r_s1     <= '0;
      end else begin
         r_s1_vld <= w_in_xfer | (r_s1_vld & ~w_s1_adv);
         if (w_in_xfer) r_s1 <= w_dec;
      end
   end

   fp16_mag_round u_mag (
      .i_exp (r_s1.exp),
      .i_man (r_s1.man),
      .o_mag (w_mag),
      .o_big (w_big)
   );

   // Exactly 8.0 in magnitude is representable only when negative (0x8000)
   assign w_over   = w_big | w_mag[15];
   assign w_exact8 = w_big ? ((r_s1.exp == SAT_EXP) && (r_s1.man == 10'd0))
                           : (w_mag == 16'h8000);

   always_comb begin
      w_fix = '0;
      w_sat = 1'b0;
      w_nan = 1'b0;
      if (r_s1.is_nan) begin
         w_nan = 1'b1;
      end else if (!r_s1.is_zero) begin
         if (r_s1.is_inf || w_over) begin
            w_fix = r_s1.sign ? FIX_MIN : FIX_MAX;
            w_sat = r_s1.is_inf | ~(r_s1.sign & w_exact8);
         end else begin
            w_fix = r_s1.sign ? fix_q4_12_t'(16'd0 - w_mag) : fix_q4_12_t'(w_mag);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_vld <= 1'b0;
         r_fix     <= '0;
         r_sat     <= 1'b0;
         r_nan     <= 1'b0;
         r_sat_cnt <= '0;
      end else begin
         r_out_vld <= w_s1_adv | (r_out_vld & ~out_ready);
         if (w_s1_adv) begin
            r_fix <= w_fix;
            r_sat <= w_sat;
            r_nan <= w_nan;
         end
         if (w_out_xfer && r_sat && (r_sat_cnt != 16'hFFFF))
            r_sat_cnt <= r_sat_cnt + 16'd1;
      end
   end

   assign out_valid = r_out_vld;
   assign fix_out   = r_fix;
   assign out_sat   = r_sat;
   assign out_nan   = r_nan;
   assign sat_count = r_sat_cnt;
endmodule

// File: tb/tb_fp16_to_fixed_conv.sv
// Self-checking bench for fp16_to_fixed_conv: directed vectors, stall/backpressure,
// mid-flight reset and randomized traffic against a real-arithmetic reference model.
module tb_fp16_to_fixed_conv;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] fp16_in = 16'd0;
   logic        in_ready, out_valid, out_sat, out_nan;
   logic [15:0] fix_out, sat_count;

   fp16_to_fixed_conv dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fp16_in   (fp16_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fix_out   (fix_out),
      .out_sat   (out_sat),
      .out_nan   (out_nan),
      .sat_count (sat_count)
   );

   always #5 clk = ~clk;

`ifdef FP16_CONV_RNE_EN
   localparam bit          RNE = 1'b1;
   localparam logic [15:0] FX_0A00 = 16'h0001;
`else
   localparam bit          RNE = 1'b0;
   localparam logic [15:0] FX_0A00 = 16'h0000;
`endif

   typedef struct {
      logic [15:0] fx;
      logic        s;
      logic        n;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad = 0;
   int          n_out = 0;
   logic [15:0] exp_sc = 16'd0;
   bit          prev_hold = 1'b0;
   logic [15:0] pfix;
   logic        psat, pnan;
   bit          use_dir = 1'b0;
   exp_t        dir_exp;
   bit          saw_nr = 1'b0;

   logic [15:0] d_op [13] = '{16'h3C00, 16'hC000, 16'h0C00, 16'h4800, 16'hC800, 16'hFC00,
                              16'h7E00, 16'h0200, 16'h0A00, 16'h0800, 16'h47FF, 16'h7C00,
                              16'h8000};
   logic [15:0] d_fx [13] = '{16'h1000, 16'hE000, 16'h0001, 16'h7FFF, 16'h8000, 16'h8000,
                              16'h0000, 16'h0000, FX_0A00, 16'h0000, 16'h7FF0, 16'h7FFF,
                              16'h0000};
   logic        d_s  [13] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0};
   logic        d_n  [13] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   // Value = (1 + man/1024) * 2^(exp-15), expressed in units of 2^-12
   function automatic exp_t ref_conv(input logic [15:0] f);
      exp_t r;
      int   e = int'(f[14:10]);
      int   m = int'(f[9:0]);
      real  v, fl;
      r = '{16'h0000, 1'b0, 1'b0};
      if (e == 31 && m != 0) begin
         r.n = 1'b1;
         return r;
      end
      if (e == 0) return r;
      if (e == 31) v = 1.0e9;
      else begin
         v = (1024.0 + m) * 4.0;
         for (int k = 0; k < e - 15; k++) v = v * 2.0;
         for (int k = 0; k < 15 - e; k++) v = v / 2.0;
      end
      fl = $floor(v);
      if (RNE && ((v - fl > 0.5) || ((v - fl == 0.5) && ($rtoi(fl) % 2 == 1)))) fl = fl + 1.0;
      if (!f[15]) begin
         if (fl >= 32768.0) begin r.fx = 16'h7FFF; r.s = 1'b1; end
         else r.fx = 16'($rtoi(fl));
      end else begin
         if (fl > 32768.0) begin r.fx = 16'h8000; r.s = 1'b1; end
         else r.fx = 16'(-$rtoi(fl));
      end
      return r;
   endfunction

   // One cycle: drive at negedge, sample 1 ns later, then wait for next negedge
   task automatic cyc(input logic iv, input logic [15:0] d, input logic ordy, output logic took);
      exp_t e;
      in_valid  = iv;
      fp16_in   = d;
      out_ready = ordy;
      #1;
      took = iv && in_ready;
      if (iv && !in_ready) saw_nr = 1'b1;
      chk("sat_count", sat_count, exp_sc);
      if (prev_hold) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_fix", fix_out, pfix);
         chk("hold_sat", out_sat, psat);
         chk("hold_nan", out_nan, pnan);
      end
      if (out_valid && out_ready) begin
         if (q.size() == 0) chk("spurious_out", out_valid, 0);
         else begin
            e = q.pop_front();
            chk("fix_out", fix_out, e.fx);
            chk("out_sat", out_sat, e.s);
            chk("out_nan", out_nan, e.n);
            n_out++;
            if (e.s && exp_sc != 16'hFFFF) exp_sc++;
         end
      end
      if (took) q.push_back(use_dir ? dir_exp : ref_conv(d));
      prev_hold = out_valid && !out_ready;
      pfix = fix_out;
      psat = out_sat;
      pnan = out_nan;
      @(negedge clk);
   endtask

   task automatic drain();
      logic took;
      for (int k = 0; k < 20 && q.size() != 0; k++) cyc(1'b0, 16'h0, 1'b1, took);
      chk("drain_empty", q.size(), 0);
   endtask

   initial begin
      logic        took;
      int          idx, n0;
      logic [15:0] d;
      logic [15:0] sops [5];

      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_fix_out", fix_out, 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_out_nan", out_nan, 0);
      chk("rst_sat_count", sat_count, 0);
      rst = 1'b0;
      #1 chk("rst_in_ready", in_ready, 1);
      @(negedge clk);

      // Directed vectors back-to-back; also checks 2-cycle latency and 1/cycle rate
      use_dir = 1'b1;
      for (int i = 0; i < 13; i++) begin
         dir_exp = '{d_fx[i], d_s[i], d_n[i]};
         cyc(1'b1, d_op[i], 1'b1, took);
         chk("dir_accept", took, 1);
         chk("latency", n_out, (i >= 2) ? i - 1 : 0);
      end
      use_dir = 1'b0;
      drain();
      chk("dir_sat_count", sat_count, 3);

      // Five operands with a 3-cycle downstream stall mid-stream
      for (int i = 0; i < 5; i++) sops[i] = 16'h3000 + 16'(i * 16'h0123);
      idx = 0;
      n0 = n_out;
      saw_nr = 1'b0;
      for (int t = 0; t < 20; t++) begin
         cyc(idx < 5, sops[(idx < 5) ? idx : 0], !(t >= 3 && t < 6), took);
         if (took) idx++;
      end
      chk("stall_backpressure", saw_nr, 1);
      chk("stall_count", n_out - n0, 5);
      drain();

      // Randomized traffic with random valid/ready
      d = 16'h0;
      took = 1'b1;
      for (int t = 0; t < 600; t++) begin
         if (took) begin
            d = 16'($urandom);
            if ($urandom % 2 == 1) d[14:10] = 5'($urandom_range(0, 19));
         end
         cyc(($urandom % 4) != 0, d, ($urandom % 4) != 0, took);
      end
      drain();

      // Reset with two operands in flight
      cyc(1'b1, 16'h4000, 1'b0, took);
      cyc(1'b1, 16'hC400, 1'b0, took);
      rst = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_sat_count", sat_count, 0);
      q.delete();
      exp_sc = 16'd0;
      prev_hold = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int t = 0; t < 6; t++) cyc(1'b0, 16'h0, 1'b1, took);
      chk("post_rst_in_ready", in_ready, 1);
      cyc(1'b1, 16'h3C00, 1'b1, took);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
